// File: rtl/sp3_demux_pkg.sv
// rtl/sp3_demux_pkg.sv - shared constants, types and bit-mapping helpers for sp3_demux_n
package sp3_demux_pkg;

    localparam int NUM_CH_DEF       = 2;
    localparam int WORD_W_DEF       = 32;
    localparam int SLIP_HOLDOFF_DEF = 16;

    typedef enum logic [0:0] {
        PS_IDLE  = 1'b0,
        PS_ARMED = 1'b1
    } phase_state_e;

    function automatic int slip_w(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

    // Channel that MGT bit j belongs to.
    function automatic int bit_ch(input int j, input int num_ch);
        return j % num_ch;
    endfunction

    // Frame-word bit index that MGT bit j lands on when accepted at phase ph.
    function automatic int bit_dst(input int j, input int ph, input int num_ch, input int word_w);
        return ph * (word_w / num_ch) + j / num_ch;
    endfunction

endpackage

// File: rtl/sp3_demux_n_if.sv
// rtl/sp3_demux_n_if.sv - MGT RX input and de-interleaved frame output bundle
interface sp3_demux_n_if #(
    parameter int NUM_CH = 2,
    parameter int WORD_W = 32,
    parameter int SW     = 5
);
    logic [WORD_W-1:0]        mgtword;
    logic                     mgtword_valid;
    logic [NUM_CH-1:0]        bitslip;
    logic                     phase_slip;
    logic [NUM_CH*WORD_W-1:0] word_out;
    logic                     word_valid;
    logic [NUM_CH*SW-1:0]     slip_val;
    logic [NUM_CH-1:0]        slip_busy;
    logic                     phase_busy;

    modport master (
        output mgtword, mgtword_valid, bitslip, phase_slip,
        input  word_out, word_valid, slip_val, slip_busy, phase_busy
    );

    modport slave (
        input  mgtword, mgtword_valid, bitslip, phase_slip,
        output word_out, word_valid, slip_val, slip_busy, phase_busy
    );
endinterface

// File: rtl/sp3_bitslip_ctrl.sv
// rtl/sp3_bitslip_ctrl.sv - slip counter with wrap-around and request hold-off
module sp3_bitslip_ctrl #(
    parameter int WORD_W  = 32,
    parameter int HOLDOFF = 16,
    parameter int SW      = 5
) (
    input  logic          mgtclk,
    input  logic          reset,
    input  logic          req,
    output logic [SW-1:0] slip_val,
    output logic          busy
);

    logic [7:0] cnt_q;

    always_ff @(posedge mgtclk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            slip_val <= '0;
        end else if (req && cnt_q == 8'd0) begin
            cnt_q    <= 8'(HOLDOFF);
            slip_val <= (slip_val == SW'(WORD_W - 1)) ? '0 : slip_val + 1'b1;
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign busy = (cnt_q != 8'd0);

endmodule

// File: rtl/sp3_demux_n.sv
// rtl/sp3_demux_n.sv - NUM_CH-way bit de-interleaver with per-channel bitslip and word-phase slip
module sp3_demux_n
    import sp3_demux_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int WORD_W       = WORD_W_DEF,
    parameter int SLIP_HOLDOFF = SLIP_HOLDOFF_DEF
) (
    input logic           mgtclk,
    input logic           reset,
    sp3_demux_n_if.slave  bus
);

    localparam int SW   = slip_w(WORD_W);
    localparam int PH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PH_W-1:0]   ph_q;
    logic [WORD_W-1:0] asm_q [NUM_CH];
    logic [WORD_W-1:0] asm_d [NUM_CH];
    logic [WORD_W-1:0] cur_q [NUM_CH];
    logic [WORD_W-1:0] out_d [NUM_CH];
    logic [SW-1:0]     slip  [NUM_CH];
    logic [NUM_CH-1:0] busy_v;
    phase_state_e      ps_q, ps_d;
    logic              accept, drop, last, ph_hold;
    logic [SW-1:0]     phase_slip_unused;

    assign last = (ph_q == PH_W'(NUM_CH - 1));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sp3_bitslip_ctrl #(.WORD_W(WORD_W), .HOLDOFF(SLIP_HOLDOFF), .SW(SW)) u_slip (
            .mgtclk   (mgtclk),
            .reset    (reset),
            .req      (bus.bitslip[c]),
            .slip_val (slip[c]),
            .busy     (busy_v[c])
        );
    end

    // Same hold-off counter, pulsed by the word drop; only its busy flag matters.
    sp3_bitslip_ctrl #(.WORD_W(WORD_W), .HOLDOFF(SLIP_HOLDOFF), .SW(SW)) u_phase (
        .mgtclk   (mgtclk),
        .reset    (reset),
        .req      (drop),
        .slip_val (phase_slip_unused),
        .busy     (ph_hold)
    );

    always_comb begin
        ps_d   = ps_q;
        drop   = 1'b0;
        accept = 1'b0;
        case (ps_q)
            PS_IDLE: begin
                accept = bus.mgtword_valid;
                if (bus.phase_slip && !ph_hold) ps_d = PS_ARMED;
            end
            PS_ARMED: begin
                if (bus.mgtword_valid) begin
                    drop = 1'b1;
                    ps_d = PS_IDLE;
                end
            end
            default: ps_d = PS_IDLE;
        endcase
    end

    always_comb begin
        logic [2*WORD_W-1:0] cat;
        logic [2*WORD_W-1:0] sh;
        cat = '0;
        sh  = '0;
        for (int c = 0; c < NUM_CH; c++) asm_d[c] = asm_q[c];
        for (int k = 0; k < NUM_CH; k++) begin
            if (ph_q == PH_W'(k)) begin
                for (int j = 0; j < WORD_W; j++)
                    asm_d[bit_ch(j, NUM_CH)][bit_dst(j, k, NUM_CH, WORD_W)] = bus.mgtword[j];
            end
        end
        // Window into {previous frame, new frame}; slip 0 selects the previous frame.
        for (int c = 0; c < NUM_CH; c++) begin
            cat      = {cur_q[c], asm_d[c]};
            sh       = cat << slip[c];
            out_d[c] = sh[2*WORD_W-1 -: WORD_W];
        end
    end

    always_ff @(posedge mgtclk or posedge reset) begin
        if (reset) begin
            ps_q           <= PS_IDLE;
            ph_q           <= '0;
            bus.word_valid <= 1'b0;
            bus.word_out   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                asm_q[c] <= '0;
                cur_q[c] <= '0;
            end
        end else begin
            ps_q           <= ps_d;
            bus.word_valid <= accept && last;
            if (accept) begin
                ph_q <= last ? '0 : ph_q + 1'b1;
                for (int c = 0; c < NUM_CH; c++) asm_q[c] <= asm_d[c];
                if (last) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        cur_q[c]                          <= asm_d[c];
                        bus.word_out[c*WORD_W +: WORD_W]  <= out_d[c];
                    end
                end
            end
        end
    end

    always_comb begin
        bus.slip_val = '0;
        for (int c = 0; c < NUM_CH; c++) bus.slip_val[c*SW +: SW] = slip[c];
    end

    assign bus.slip_busy  = busy_v;
    assign bus.phase_busy = (ps_q == PS_ARMED) || ph_hold;

endmodule
